if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Fetch-request sequencer between the PC register and the I-cache (SRAM-like req/addr_ok/data_ok).
//  Issues one request per fetch PC, tracks the single outstanding transaction, discards responses
//  orphaned by redirects, and produces the F_inst_data_ok1/2 strobes that advance the PC by 4 or 8.
// PARAMETERS
//  ADDR_W    32  fetch address width
//  CNT_W     32  perf-counter width (FETCH_PERF_CNT_EN only)
// PORTS
//  clk              in   1       clock; all state updates on posedge
//  rst              in   1       synchronous, active-high reset
//  fetch_pc         in   ADDR_W  current PC (pc_curr)
//  redirect         in   1       any PC redirect this cycle (except/pred-fail/jump-conflict/flush/branch/jump)
//  fifo_full        in   1       instruction FIFO almost full; room for exactly one more pair guaranteed
//  inst_req         out  1       I-cache request valid
//  inst_addr        out  ADDR_W  I-cache request address, word aligned
//  inst_addr_ok     in   1       request accepted this cycle
//  inst_data_ok     in   1       response valid this cycle
//  inst_rdata       in   64      {word @addr+4, word @addr}
//  F_inst_data_ok1  out  1       slot-1 instruction valid (to pc_reg and FIFO)
//  F_inst_data_ok2  out  1       slot-2 instruction valid
//  F_inst1          out  32      slot-1 instruction = inst_rdata[31:0]
//  F_inst2          out  32      slot-2 instruction = inst_rdata[63:32]
//  F_pc1            out  ADDR_W  PC of slot 1 (latched request address)
//  F_adel           out  1       fetch_pc misaligned while IDLE
//  perf_req_cnt     out  CNT_W   requests accepted
//  perf_cancel_cnt  out  CNT_W   responses discarded
//  perf_stall_cnt   out  CNT_W   cycles IDLE with fifo_full
// BEHAVIOUR
//  States: IDLE, REQ (req pending, not accepted), WAIT (accepted, awaiting data), CANCEL (awaiting data to drop).
//  At most one outstanding request; response returns >=1 cycle after addr_ok.
//  Reset: state=IDLE, addr_q=0, inst_req=0, F_inst_data_ok1/2=0, F_adel=0, counters=0; rst overrides all inputs.
//  IDLE: inst_req = !fifo_full & !redirect & (fetch_pc[1:0]==0); inst_addr = fetch_pc.
//    req & addr_ok -> WAIT; req & !addr_ok -> REQ; addr_q <= fetch_pc whenever req.
//    F_adel = (fetch_pc[1:0]!=0) & !redirect; no request issued while misaligned.
//  REQ: inst_req=1, inst_addr=addr_q (held stable).
//    addr_ok & !redirect -> WAIT; addr_ok & redirect -> CANCEL;
//    !addr_ok & redirect -> IDLE (request withdrawn); otherwise stay.
//  WAIT: inst_req=0.
//    data_ok & !redirect: F_inst_data_ok1=1, F_inst_data_ok2=!addr_q[2]; -> IDLE.
//    data_ok & redirect: both strobes 0 (response dropped, not counted as cancel) -> IDLE.
//    !data_ok & redirect -> CANCEL.
//  CANCEL: inst_req=0, strobes 0; data_ok -> IDLE (perf_cancel_cnt++); redirect ignored.
//  Strobes combinational from inst_data_ok in the delivery cycle; zero in every other cycle/state.
//  F_pc1 = addr_q; F_inst1/F_inst2 pass through inst_rdata unconditionally (qualified by strobes).
//  Second slot dropped when addr_q[2]=1 (pair crosses 8-byte line boundary).
//  fifo_full only blocks new requests in IDLE; an in-flight response is still delivered.
//  Steady-state throughput: one pair per 2 cycles with 1-cycle cache (IDLE->WAIT->IDLE).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: perf_* counters are saturating CNT_W-bit registers, cleared by rst.
//    perf_req_cnt increments on every req&addr_ok; perf_cancel_cnt as above; perf_stall_cnt per IDLE&fifo_full cycle.
//  Not defined: perf_* ports exist and are tied to 0; no counter flops synthesized.
// TESTING
//  1 rst 1 cycle, fetch_pc=bfc00000, addr_ok same cycle, data_ok next -> req@bfc00000, ok1=ok2=1, F_pc1=bfc00000.
//  2 fetch_pc=bfc00004, cache ready -> inst_addr=bfc00004, ok1=1, ok2=0 (line-boundary drop).
//  3 addr_ok withheld 3 cycles with fetch_pc changing -> inst_req high, inst_addr stays at addr_q throughout.
//  4 redirect in WAIT, data_ok 2 cycles later -> state CANCEL, strobes 0, perf_cancel_cnt=1, next req uses new pc.
//  5 fifo_full=1 in IDLE 4 cycles -> inst_req=0, perf_stall_cnt=4; deassert -> request next cycle.
//  6 rst asserted in WAIT, data_ok same cycle -> strobes 0, state IDLE, counters 0 the following cycle.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_ctrl_if
//  Description : SRAM-like I-cache fetch bus (req / addr_ok / data_ok).
//                master = fetch sequencer, slave = instruction cache.
//  Revision    : 1.0  initial release
// ============================================================================
interface if_fetch_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [63:0]       inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_ctrl
//  Description : Fetch-request sequencer between the PC register and the
//                I-cache. Issues one request per fetch PC, tracks the single
//                outstanding transaction, drops responses orphaned by
//                redirects and produces the slot-1/slot-2 valid strobes.
//  Options     : FETCH_PERF_CNT_EN - enables saturating perf_* counters;
//                when undefined the perf_* ports are tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  wire                clk,
    input  wire                rst,
    input  wire  [ADDR_W-1:0]  fetch_pc,
    input  wire                redirect,
    input  wire                fifo_full,
    if_fetch_ctrl_if.master    icache,
    output logic               F_inst_data_ok1,
    output logic               F_inst_data_ok2,
    output logic [31:0]        F_inst1,
    output logic [31:0]        F_inst2,
    output logic [ADDR_W-1:0]  F_pc1,
    output logic               F_adel,
    output logic [CNT_W-1:0]   perf_req_cnt,
    output logic [CNT_W-1:0]   perf_cancel_cnt,
    output logic [CNT_W-1:0]   perf_stall_cnt
);

    // IDLE: free to issue; REQ: request pending, not yet accepted;
    // WAIT: accepted, response owed to the pipeline;
    // CANCEL: accepted, response must be swallowed.
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_req    = 2'd1;
    localparam logic [1:0] c_st_wait   = 2'd2;
    localparam logic [1:0] c_st_cancel = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [ADDR_W-1:0] r_addr_q;
    logic              w_aligned;
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic              w_ok1;
    logic              w_ok2;
    logic              w_adel;

    assign w_aligned = (fetch_pc[1:0] == 2'b00);

    // State register and latched request address (captured whenever IDLE issues).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_addr_q <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == c_st_idle) && w_req) begin
                r_addr_q <= fetch_pc;
            end
        end
    end

    // Next-state and bus/strobe outputs; reset forces everything quiet.
    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_addr = r_addr_q;
        w_ok1  = 1'b0;
        w_ok2  = 1'b0;
        w_adel = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_addr = fetch_pc;
                w_req  = !fifo_full && !redirect && w_aligned;
                w_adel = !w_aligned && !redirect;
                if (w_req) begin
                    w_next = icache.inst_addr_ok ? c_st_wait : c_st_req;
                end
            end
            c_st_req: begin
                // Address is held at the latched value until accepted.
                w_req = 1'b1;
                if (icache.inst_addr_ok) begin
                    w_next = redirect ? c_st_cancel : c_st_wait;
                end else if (redirect) begin
                    w_next = c_st_idle;
                end
            end
            c_st_wait: begin
                if (icache.inst_data_ok) begin
                    // A redirect in the delivery cycle just drops the pair.
                    if (!redirect) begin
                        w_ok1 = 1'b1;
                        w_ok2 = !r_addr_q[2];
                    end
                    w_next = c_st_idle;
                end else if (redirect) begin
                    w_next = c_st_cancel;
                end
            end
            c_st_cancel: begin
                if (icache.inst_data_ok) begin
                    w_next = c_st_idle;
                end
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
        if (rst) begin
            w_req  = 1'b0;
            w_ok1  = 1'b0;
            w_ok2  = 1'b0;
            w_adel = 1'b0;
            w_next = c_st_idle;
        end
    end

    assign icache.inst_req  = w_req;
    assign icache.inst_addr = w_addr;
    assign F_inst_data_ok1  = w_ok1;
    assign F_inst_data_ok2  = w_ok2;
    assign F_inst1          = icache.inst_rdata[31:0];
    assign F_inst2          = icache.inst_rdata[63:32];
    assign F_pc1            = r_addr_q;
    assign F_adel           = w_adel;

`ifdef FETCH_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic             w_req_evt;
    logic             w_cancel_evt;
    logic             w_stall_evt;
    logic [CNT_W-1:0] r_perf_req;
    logic [CNT_W-1:0] r_perf_cancel;
    logic [CNT_W-1:0] r_perf_stall;

    assign w_req_evt    = w_req && icache.inst_addr_ok;
    assign w_cancel_evt = (r_state == c_st_cancel) && icache.inst_data_ok;
    assign w_stall_evt  = (r_state == c_st_idle) && fifo_full;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_req    <= '0;
            r_perf_cancel <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_req_evt && (r_perf_req != c_cnt_max)) begin
                r_perf_req <= r_perf_req + c_cnt_one;
            end
            if (w_cancel_evt && (r_perf_cancel != c_cnt_max)) begin
                r_perf_cancel <= r_perf_cancel + c_cnt_one;
            end
            if (w_stall_evt && (r_perf_stall != c_cnt_max)) begin
                r_perf_stall <= r_perf_stall + c_cnt_one;
            end
        end
    end

    assign perf_req_cnt    = r_perf_req;
    assign perf_cancel_cnt = r_perf_cancel;
    assign perf_stall_cnt  = r_perf_stall;
`else
    assign perf_req_cnt    = '0;
    assign perf_cancel_cnt = '0;
    assign perf_stall_cnt  = '0;
`endif

endmodule
`default_nettype wire
